// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, operand-2 select and ALU op decode.
// Optional feature macro: IDEX_FORWARD_EN (EX/MEM and MEM/WB forwarding muxes).
module idex_operand_stage #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned REGIDX_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [REGIDX_W-1:0] id_rs1,
    input  logic [REGIDX_W-1:0] id_rs2,
    input  logic [REGIDX_W-1:0] id_rd,
    input  logic [1:0]          id_aluop,
    input  logic [2:0]          id_funct3,
    input  logic                id_funct7b5,
    input  logic                id_alusrc,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                id_memwrite,
    input  logic                id_memtoreg,
    input  logic                exmem_regwrite,
    input  logic [REGIDX_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]     exmem_result,
    input  logic                memwb_regwrite,
    input  logic [REGIDX_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]     memwb_data,
    output logic [XLEN-1:0]     alu_data1,
    output logic [XLEN-1:0]     alu_data2,
    output logic [3:0]          alu_op,
    output logic                ex_valid,
    output logic [REGIDX_W-1:0] ex_rd,
    output logic [XLEN-1:0]     ex_store_data,
    output logic                ex_regwrite,
    output logic                ex_memread,
    output logic                ex_memwrite,
    output logic                ex_memtoreg
);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_ZERO = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [REGIDX_W-1:0] rs1;
        logic [REGIDX_W-1:0] rs2;
        logic [REGIDX_W-1:0] rd;
        logic [1:0]          aluop;
        logic [2:0]          funct3;
        logic                funct7b5;
        logic                alusrc;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                memtoreg;
    } idex_t;

    idex_t    stage_q, stage_d;
    logic [XLEN-1:0] opa, opb;
    alu_op_e  op_dec;

    // Flush outranks stall; an invalid capture carries no control side effects.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!stall) begin
            stage_d.valid    = id_valid;
            stage_d.rs1_data = id_rs1_data;
            stage_d.rs2_data = id_rs2_data;
            stage_d.imm      = id_imm;
            stage_d.rs1      = id_rs1;
            stage_d.rs2      = id_rs2;
            stage_d.rd       = id_rd;
            stage_d.aluop    = id_aluop;
            stage_d.funct3   = id_funct3;
            stage_d.funct7b5 = id_funct7b5;
            stage_d.alusrc   = id_alusrc;
            stage_d.regwrite = id_regwrite & id_valid;
            stage_d.memread  = id_memread  & id_valid;
            stage_d.memwrite = id_memwrite & id_valid;
            stage_d.memtoreg = id_memtoreg & id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

`ifdef IDEX_FORWARD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
    always_comb begin
        opa = stage_q.rs1_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == stage_q.rs1)) begin
            opa = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == stage_q.rs1)) begin
            opa = memwb_data;
        end
    end

    always_comb begin
        opb = stage_q.rs2_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == stage_q.rs2)) begin
            opb = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == stage_q.rs2)) begin
            opb = memwb_data;
        end
    end
`else
    logic unused_fwd;

    assign opa = stage_q.rs1_data;
    assign opb = stage_q.rs2_data;
    assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_data,
                          stage_q.rs1, stage_q.rs2};
`endif

    always_comb begin
        op_dec = ALU_ZERO;
        unique case (stage_q.aluop)
            2'b00: op_dec = ALU_ADD;
            2'b01: op_dec = ALU_SUB;
            2'b10: begin
                unique case (stage_q.funct3)
                    3'b000:  op_dec = (stage_q.funct7b5 && !stage_q.alusrc) ? ALU_SUB : ALU_ADD;
                    3'b111:  op_dec = ALU_AND;
                    3'b110:  op_dec = ALU_OR;
                    default: op_dec = ALU_ZERO;
                endcase
            end
            default: op_dec = ALU_ZERO;
        endcase
    end

    assign alu_data1     = opa;
    assign alu_data2     = stage_q.alusrc ? stage_q.imm : opb;
    assign alu_op        = op_dec;
    assign ex_store_data = opb;
    assign ex_valid      = stage_q.valid;
    assign ex_rd         = stage_q.rd;
    assign ex_regwrite   = stage_q.regwrite;
    assign ex_memread    = stage_q.memread;
    assign ex_memwrite   = stage_q.memwrite;
    assign ex_memtoreg   = stage_q.memtoreg;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Self-checking bench for idex_operand_stage: directed vector table, hand sequences, random vs model.
module tb_idex_operand_stage;

    localparam int XLEN = 64;
    localparam int RW   = 5;
`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset, stall, flush, id_valid;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [RW-1:0]   id_rs1, id_rs2, id_rd;
    logic [1:0]      id_aluop;
    logic [2:0]      id_funct3;
    logic            id_funct7b5, id_alusrc;
    logic            id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic            exmem_regwrite, memwb_regwrite;
    logic [RW-1:0]   exmem_rd, memwb_rd;
    logic [XLEN-1:0] exmem_result, memwb_data;
    logic [XLEN-1:0] alu_data1, alu_data2, ex_store_data;
    logic [3:0]      alu_op;
    logic            ex_valid;
    logic [RW-1:0]   ex_rd;
    logic            ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

    idex_operand_stage #(.XLEN(64), .REGIDX_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_aluop(id_aluop), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
    );

    always #5 clk = ~clk;

    // Instruction as the EX stage should currently hold it.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] r1d, r2d, imm;
        logic [RW-1:0]   rs1, rs2, rd;
        logic [1:0]      aluop;
        logic [2:0]      f3;
        logic            f7, alusrc;
        logic [3:0]      ctl;
    } inst_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] r1d, r2d, imm;
        logic [RW-1:0]   rs1, rs2, rd;
        logic [1:0]      aluop;
        logic [2:0]      f3;
        logic            f7, alusrc;
        logic [3:0]      ctl;
        logic [3:0]      e_op;
        logic [XLEN-1:0] e_d1, e_d2, e_st;
        logic [3:0]      e_ctl;
    } vec_t;

    inst_t m = '0;
    vec_t  vecs[11];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] idx, input logic [XLEN-1:0] regv);
        if (FWD && exmem_regwrite && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
        if (FWD && memwb_regwrite && memwb_rd != 0 && memwb_rd == idx) return memwb_data;
        return regv;
    endfunction

    function automatic logic [3:0] exp_op(input inst_t i);
        case (i.aluop)
            2'd0: return 4'b0010;
            2'd1: return 4'b0110;
            2'd2: begin
                if (i.f3 == 3'b000) return (i.f7 && !i.alusrc) ? 4'b0110 : 4'b0010;
                if (i.f3 == 3'b111) return 4'b0000;
                if (i.f3 == 3'b110) return 4'b0001;
                return 4'b1111;
            end
            default: return 4'b1111;
        endcase
    endfunction

    function automatic inst_t id_now();
        inst_t i;
        i.valid = id_valid;  i.r1d = id_rs1_data; i.r2d = id_rs2_data; i.imm = id_imm;
        i.rs1 = id_rs1;      i.rs2 = id_rs2;      i.rd = id_rd;
        i.aluop = id_aluop;  i.f3 = id_funct3;    i.f7 = id_funct7b5; i.alusrc = id_alusrc;
        i.ctl = {id_regwrite, id_memread, id_memwrite, id_memtoreg} & {4{id_valid}};
        return i;
    endfunction

    // Advance one clock; the model takes the inputs present before the edge.
    task automatic tick();
        inst_t nxt;
        nxt = m;
        if (reset || flush) nxt = '0;
        else if (!stall)    nxt = id_now();
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic load_id(input logic v, input logic [63:0] r1d, r2d, imm,
                           input logic [4:0] rs1, rs2, rd, input logic [1:0] aluop,
                           input logic [2:0] f3, input logic f7, alusrc, input logic [3:0] ctl);
        id_valid = v; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_aluop = aluop; id_funct3 = f3;
        id_funct7b5 = f7; id_alusrc = alusrc;
        {id_regwrite, id_memread, id_memwrite, id_memtoreg} = ctl;
    endtask

    task automatic rand_id();
        load_id(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    endtask

    task automatic rand_fwd();
        exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
        exmem_result   = {$urandom, $urandom};
        memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
        memwb_data     = {$urandom, $urandom};
    endtask

    task automatic check_model(input string tag);
        logic [XLEN-1:0] fa, fb;
        fa = fwd(m.rs1, m.r1d);
        fb = fwd(m.rs2, m.r2d);
        chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(m.valid));
        chk({tag, ".alu_op"}, 64'(alu_op), 64'(exp_op(m)));
        chk({tag, ".alu_data1"}, alu_data1, fa);
        chk({tag, ".alu_data2"}, alu_data2, m.alusrc ? m.imm : fb);
        chk({tag, ".ex_store_data"}, ex_store_data, fb);
        chk({tag, ".ex_rd"}, 64'(ex_rd), 64'(m.rd));
        chk({tag, ".ctl"}, 64'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}), 64'(m.ctl));
    endtask

    initial begin
        // ctl/e_ctl order: {regwrite, memread, memwrite, memtoreg}
        vecs[0]  = '{1'b1, 64'd100, 64'd30, 64'd0, 5'd5, 5'd6, 5'd7, 2'b10, 3'b000, 1'b1, 1'b0, 4'b1000,
                     4'b0110, 64'd100, 64'd30, 64'd30, 4'b1000};
        vecs[1]  = '{1'b1, 64'd7, 64'd55, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 5'd9, 5'd10, 2'b10, 3'b000, 1'b1, 1'b1,
                     4'b1000, 4'b0010, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd55, 4'b1000};
        vecs[2]  = '{1'b1, 64'd1000, 64'd77, 64'd16, 5'd1, 5'd2, 5'd11, 2'b00, 3'b011, 1'b0, 1'b1, 4'b1101,
                     4'b0010, 64'd1000, 64'd16, 64'd77, 4'b1101};
        vecs[3]  = '{1'b1, 64'd2000, 64'd88, 64'd8, 5'd3, 5'd4, 5'd0, 2'b00, 3'b011, 1'b0, 1'b1, 4'b0010,
                     4'b0010, 64'd2000, 64'd8, 64'd88, 4'b0010};
        vecs[4]  = '{1'b1, 64'd9, 64'd4, 64'h20, 5'd5, 5'd6, 5'd0, 2'b01, 3'b000, 1'b0, 1'b0, 4'b0000,
                     4'b0110, 64'd9, 64'd4, 64'd4, 4'b0000};
        vecs[5]  = '{1'b1, 64'hF0F0, 64'h0FF0, 64'd0, 5'd1, 5'd2, 5'd3, 2'b10, 3'b111, 1'b0, 1'b0, 4'b1000,
                     4'b0000, 64'hF0F0, 64'h0FF0, 64'h0FF0, 4'b1000};
        vecs[6]  = '{1'b1, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd3, 2'b10, 3'b110, 1'b0, 1'b0, 4'b1000,
                     4'b0001, 64'd1, 64'd2, 64'd2, 4'b1000};
        vecs[7]  = '{1'b1, 64'd5, 64'd6, 64'd3, 5'd1, 5'd2, 5'd3, 2'b10, 3'b010, 1'b0, 1'b1, 4'b1000,
                     4'b1111, 64'd5, 64'd3, 64'd6, 4'b1000};
        vecs[8]  = '{1'b1, 64'd5, 64'd6, 64'd0, 5'd1, 5'd2, 5'd3, 2'b11, 3'b000, 1'b1, 1'b0, 4'b1000,
                     4'b1111, 64'd5, 64'd6, 64'd6, 4'b1000};
        vecs[9]  = '{1'b0, 64'd42, 64'd43, 64'd44, 5'd1, 5'd2, 5'd3, 2'b00, 3'b000, 1'b0, 1'b0, 4'b1111,
                     4'b0010, 64'd42, 64'd43, 64'd43, 4'b0000};
        vecs[10] = '{1'b1, 64'd10, 64'd20, 64'd0, 5'd1, 5'd2, 5'd3, 2'b10, 3'b000, 1'b0, 1'b0, 4'b1000,
                     4'b0010, 64'd10, 64'd20, 64'd20, 4'b1000};

        // Reset with everything else random.
        rand_id(); rand_fwd();
        stall = 1'($urandom); flush = 1'($urandom); reset = 1'b1;
        tick(); tick();
        chk("rst.ex_valid", 64'(ex_valid), 64'd0);
        chk("rst.alu_op", 64'(alu_op), 64'b0010);
        chk("rst.alu_data1", alu_data1, 64'd0);
        chk("rst.alu_data2", alu_data2, 64'd0);
        chk("rst.ex_store_data", ex_store_data, 64'd0);
        chk("rst.ex_rd", 64'(ex_rd), 64'd0);
        chk("rst.ctl", 64'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}), 64'd0);

        // Directed vector table, no forwarding sources active.
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        for (int i = 0; i < 11; i++) begin
            load_id(vecs[i].valid, vecs[i].r1d, vecs[i].r2d, vecs[i].imm, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].rd, vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].alusrc, vecs[i].ctl);
            tick();
            chk($sformatf("vec%0d.alu_op", i), 64'(alu_op), 64'(vecs[i].e_op));
            chk($sformatf("vec%0d.alu_data1", i), alu_data1, vecs[i].e_d1);
            chk($sformatf("vec%0d.alu_data2", i), alu_data2, vecs[i].e_d2);
            chk($sformatf("vec%0d.store", i), ex_store_data, vecs[i].e_st);
            chk($sformatf("vec%0d.ex_valid", i), 64'(ex_valid), 64'(vecs[i].valid));
            chk($sformatf("vec%0d.ex_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
            chk($sformatf("vec%0d.ctl", i), 64'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}),
                64'(vecs[i].e_ctl));
        end

        // Forwarding priority and x0 exclusion.
        load_id(1'b1, 64'd1, 64'd0, 64'd0, 5'd3, 5'd0, 5'd9, 2'b00, 3'b000, 1'b0, 1'b0, 4'b1000);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 64'hAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_data = 64'hBB;
        #1 chk("fwd.exmem_wins", alu_data1, FWD ? 64'hAA : 64'd1);
        exmem_regwrite = 1'b0;
        #1 chk("fwd.memwb", alu_data1, FWD ? 64'hBB : 64'd1);
        load_id(1'b1, 64'h55, 64'd0, 64'd0, 5'd0, 5'd0, 5'd9, 2'b00, 3'b000, 1'b0, 1'b0, 4'b1000);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1 chk("fwd.x0_never", alu_data1, 64'h55);

        // Stall for 3 cycles against changing decode inputs, forwarding still live, then flush+stall.
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        load_id(vecs[0].valid, vecs[0].r1d, vecs[0].r2d, vecs[0].imm, vecs[0].rs1, vecs[0].rs2,
                vecs[0].rd, vecs[0].aluop, vecs[0].f3, vecs[0].f7, vecs[0].alusrc, vecs[0].ctl);
        tick();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_id();
            tick();
            chk($sformatf("stall%0d.alu_op", c), 64'(alu_op), 64'b0110);
            chk($sformatf("stall%0d.alu_data1", c), alu_data1, 64'd100);
            chk($sformatf("stall%0d.alu_data2", c), alu_data2, 64'd30);
            chk($sformatf("stall%0d.ex_rd", c), 64'(ex_rd), 64'd7);
            chk($sformatf("stall%0d.valid_rw", c), 64'({ex_valid, ex_regwrite}), 64'b11);
        end
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 64'hDEAD;
        #1 chk("stall.fwd_reeval", alu_data1, FWD ? 64'hDEAD : 64'd100);
        exmem_regwrite = 1'b0;
        id_valid = 1'b1; id_regwrite = 1'b1; id_memwrite = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush.ex_valid", 64'(ex_valid), 64'd0);
        chk("flush.ex_regwrite", 64'(ex_regwrite), 64'd0);
        chk("flush.ex_memwrite", 64'(ex_memwrite), 64'd0);

        // Reset asserted mid-stall.
        flush = 1'b0; stall = 1'b0;
        load_id(vecs[2].valid, vecs[2].r1d, vecs[2].r2d, vecs[2].imm, vecs[2].rs1, vecs[2].rs2,
                vecs[2].rd, vecs[2].aluop, vecs[2].f3, vecs[2].f7, vecs[2].alusrc, vecs[2].ctl);
        tick();
        stall = 1'b1; reset = 1'b1;
        tick();
        chk("rststall.ex_valid", 64'(ex_valid), 64'd0);
        chk("rststall.alu_data1", alu_data1, 64'd0);
        chk("rststall.ctl", 64'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}), 64'd0);
        reset = 1'b0; stall = 1'b0;

        // Store: rs2 forwarded from MEM/WB while operand 2 is the immediate.
        load_id(1'b1, 64'd0, 64'h5555, 64'h40, 5'd0, 5'd12, 5'd0, 2'b00, 3'b011, 1'b0, 1'b1, 4'b0010);
        tick();
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b1; memwb_rd = 5'd12; memwb_data = 64'h1234;
        #1;
        chk("store.ex_store_data", ex_store_data, FWD ? 64'h1234 : 64'h5555);
        chk("store.alu_data2", alu_data2, 64'h40);
        chk("store.ex_memwrite", 64'(ex_memwrite), 64'd1);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            rand_id();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 29) == 0);
            tick();
            rand_fwd();
            #1 check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/idex_operand_stage.md
Name: idex_operand_stage

Overview:
- ID/EX pipeline register plus operand-select logic that directly feeds the 64-bit ALU (inputs data1, data2, op).
- Latches decoded instruction fields from the decode stage.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Selects the register or immediate operand, and translates the 2-bit main-decoder aluop plus funct bits into the ALU's 4-bit op code.

Parameters:
- XLEN, 64, datapath width; must match the ALU width.
- REGIDX_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold the pipeline register contents
- flush  input  1  replace the captured instruction with a bubble
- id_valid  input  1  decode presents a valid instruction
- id_rs1_data  input  XLEN  register file read port 1
- id_rs2_data  input  XLEN  register file read port 2
- id_imm  input  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  input  REGIDX_W  register indices
- id_aluop  input  2  main-decoder ALU class
- id_funct3  input  3  instruction funct3
- id_funct7b5  input  1  instruction bit 30
- id_alusrc  input  1  1 selects the immediate as operand 2
- id_regwrite, id_memread, id_memwrite, id_memtoreg  input  1 each  control bits
- exmem_regwrite  input  1  EX/MEM will write rd
- exmem_rd  input  REGIDX_W  EX/MEM destination register
- exmem_result  input  XLEN  EX/MEM ALU result
- memwb_regwrite  input  1  MEM/WB will write rd
- memwb_rd  input  REGIDX_W  MEM/WB destination register
- memwb_data  input  XLEN  MEM/WB writeback value
- alu_data1  output  XLEN  to ALU data1
- alu_data2  output  XLEN  to ALU data2
- alu_op  output  4  to ALU op
- ex_valid  output  1  EX-stage instruction is valid
- ex_rd  output  REGIDX_W  registered rd
- ex_store_data  output  XLEN  forwarded rs2 value, for stores
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  output  1 each  registered control bits, gated by valid

Behaviour:
- Register update on rising clk, evaluated in priority order:
  - reset: all registered fields cleared to 0.
  - else flush: ex_valid=0 and all control bits cleared; data fields are don't-care but are cleared to 0. Flush wins over stall.
  - else stall: all registers hold.
  - else: capture all id_* fields; ex_valid <= id_valid.
- A captured instruction with id_valid=0 has its control bits cleared, the same as a bubble.
- Latency: one cycle from decode inputs to the EX outputs.
- Forwarding and ALU decode are combinational from the registered fields and the current exmem_*/memwb_* inputs, so there is zero added latency into the ALU.
- Operand A forwarding, highest priority first:
  - exmem_regwrite && exmem_rd!=0 && exmem_rd==rs1 -> exmem_result
  - else memwb_regwrite && memwb_rd!=0 && memwb_rd==rs1 -> memwb_data
  - else registered rs1_data.
- Operand B (forwarded rs2) uses the same rule on rs2.
- Register x0 is never forwarded.
- alu_data1 = forwarded A.
- alu_data2 = registered imm if alusrc=1, else forwarded B.
- ex_store_data = forwarded B, regardless of alusrc.
- alu_op decode:
  - aluop 00 -> 0010 (add; loads/stores)
  - aluop 01 -> 0110 (sub; branches)
  - aluop 10 -> R/I-type, by funct3:
    - funct3 000: 0110 if funct7b5=1 and alusrc=0, else 0010
    - funct3 111: 0000
    - funct3 110: 0001
    - any other funct3: 1111
  - aluop 11 -> 1111
  - 1111 yields a zero result in the ALU.
- Reset values:
  - ex_valid=0, all ex_* control bits=0, ex_rd=0.
  - alu_data1=0, alu_data2=0, ex_store_data=0. These hold because rs=0 is never forwarded.
  - alu_op=0010.
- While stalled, the held instruction continues to re-evaluate forwarding every cycle against the current exmem/memwb inputs.
- Reset asserted mid-stall clears the stage at the next edge.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined: forwarding exactly as specified in Behaviour.
- Undefined: the forwarding muxes are removed and operands come from the registered register-file data only. The exmem_*/memwb_* inputs are ignored but remain ports. Hazards are then the hazard unit's job via stall.

Test Plan:
- Reset with all inputs random -> ex_valid=0, alu_op=0010, alu_data1=0, alu_data2=0, all control bits 0.
- Decode R-type sub: rs1=5 data 100, rs2=6 data 30, aluop=10, funct3=000, funct7b5=1 -> next cycle alu_op=0110, data1=100, data2=30.
- I-type: rs1 data 7, imm=-1, alusrc=1, aluop=10, funct3=000, funct7b5=1 -> alu_op=0010 (not sub), data2=0xFFFF_FFFF_FFFF_FFFF.
- Forwarding priority: registered rs1=3 (data 1); exmem_rd=3 with result 0xAA; memwb_rd=3 with data 0xBB; both regwrite=1 -> data1=0xAA. Drop exmem_regwrite -> data1=0xBB. Set rs1=0 with both forwards matching rd=0 -> data1 = registered value.
- Stall held for 3 cycles with new id_* inputs -> ex_* outputs unchanged. Assert flush together with stall -> next cycle ex_valid=0, ex_regwrite=0, ex_memwrite=0.
- Store with alusrc=1, rs2 forwarded from memwb (0x1234) -> ex_store_data=0x1234, alu_data2=imm. With IDEX_FORWARD_EN undefined -> ex_store_data = registered rs2 data.
